ram_sdp_sync_clr: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on a single clock.
- Provides selectable read latency, selectable read-during-write semantics and a hardware clear sequencer that fills every word with INIT_VALUE after reset or on request.
- Holds LDPC decoder message and LLR storage that must be zeroed between codewords without spending bus cycles on it.

---
 rtl/ram_sdp_sync_clr.sv | 152 +++++++++++++++
 tb/tb_ram_sdp_sync_clr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_sync_clr.sv
// Simple-dual-port synchronous RAM with selectable read latency, read-during-write
// behaviour, and a hardware sequencer that fills every word with INIT_VALUE.
//
// state | meaning
// CLEAR | writing INIT_VALUE to mem[clr_cnt]; port traffic ignored
// IDLE  | normal read/write service; clr_req starts a new clear
module ram_sdp_sync_clr #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int                    OUT_REG     = 0,
    parameter int                    WRITE_FIRST = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
    logic                    wr_ok, rd_ok;
    logic                    wr_fire, rd_fire;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    generate
        if (RAM_DEPTH >= (1 << ADDR_WIDTH)) begin : g_full
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_part
            localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(RAM_DEPTH);
            assign wr_ok = (wr_addr < DEPTH_A);
            assign rd_ok = (rd_addr < DEPTH_A);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign init_busy = (state == CLEAR);

    // A clear request takes priority over a write issued in the same cycle.
    assign wr_fire = (state == IDLE) && wr_en && !clr_req && wr_ok;
    assign rd_fire = (state == IDLE) && rd_en;

    always_comb begin
        mem_we    = wr_fire;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = INIT_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word = INIT_VALUE;
        if (!rd_ok) begin
            rd_word = INIT_VALUE;
        end else if ((WRITE_FIRST != 0) && wr_fire && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end else begin
            rd_word = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_out_direct
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end else begin : g_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_sync_clr.sv
// Bench for ram_sdp_sync_clr: three configurations share one stimulus stream and
// each is checked against its own reference memory and a read scoreboard.
module tb_ram_sdp_sync_clr;

    logic       clk;
    logic       rst_n = 1'b1;
    logic       clr_req = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;

    logic [2:0]      ib;
    logic [2:0]      rv;
    logic [2:0][7:0] rdd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         dep [3];
    int         lat [3];
    int         wf  [3];
    logic [7:0] iv  [3];

    bit         mbusy [3];
    int         mcnt  [3];
    logic [7:0] m     [3][16];
    logic [7:0] last  [3];

    typedef struct {
        int         inst;
        int         due;
        logic [7:0] d;
    } ent_t;
    ent_t sb[$];

    ram_sdp_sync_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16), .OUT_REG(0),
                       .WRITE_FIRST(1), .INIT_VALUE(8'h00)) u0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(ib[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rv[0]));

    ram_sdp_sync_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16), .OUT_REG(1),
                       .WRITE_FIRST(0), .INIT_VALUE(8'h00)) u1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(ib[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rv[1]));

    ram_sdp_sync_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(12), .OUT_REG(0),
                       .WRITE_FIRST(1), .INIT_VALUE(8'h5A)) u2 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(ib[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_valid(rv[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input int i);
        int idx;
        idx = -1;
        check($sformatf("init_busy%0d@%0d", i, cyc), 32'(ib[i]), 32'(mbusy[i]));
        for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].inst == i && sb[k].due == cyc) idx = k;
        end
        if (idx >= 0) begin
            check($sformatf("rd_valid%0d@%0d", i, cyc), 32'(rv[i]), 32'd1);
            check($sformatf("rd_data%0d@%0d", i, cyc), 32'(rdd[i]), 32'(sb[idx].d));
            last[i] = sb[idx].d;
            sb.delete(idx);
        end else begin
            check($sformatf("rd_idle%0d@%0d", i, cyc), 32'(rv[i]), 32'd0);
            check($sformatf("rd_hold%0d@%0d", i, cyc), 32'(rdd[i]), 32'(last[i]));
        end
    endtask

    task automatic step(input logic c, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic re, input logic [3:0] ra);
        ent_t e;
        clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        for (int i = 0; i < 3; i++) begin
            if (mbusy[i]) begin
                m[i][mcnt[i]] = iv[i];
                if (mcnt[i] == dep[i] - 1) begin
                    mbusy[i] = 1'b0;
                    mcnt[i]  = 0;
                end else begin
                    mcnt[i]++;
                end
            end else begin
                if (re) begin
                    e.inst = i;
                    e.due  = cyc + lat[i];
                    if (int'(ra) >= dep[i]) e.d = iv[i];
                    else if (wf[i] != 0 && we && !c && wa == ra) e.d = wd;
                    else e.d = m[i][ra];
                    sb.push_back(e);
                end
                if (we && !c && int'(wa) < dep[i]) m[i][wa] = wd;
                if (c) begin
                    mbusy[i] = 1'b1;
                    mcnt[i]  = 0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 3; i++) check_out(i);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(a));
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        step(1'b0, 1'b1, 4'(a), d, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mbusy[i] = 1'b1;
            mcnt[i]  = 0;
            last[i]  = 8'h00;
        end
        sb.delete();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid%0d", i), 32'(rv[i]), 32'd0);
            check($sformatf("rst_data%0d", i), 32'(rdd[i]), 32'd0);
            check($sformatf("rst_busy%0d", i), 32'(ib[i]), 32'd1);
        end
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic count_busy();
        int n [3];
        for (int i = 0; i < 3; i++) n[i] = 0;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 3; i++) if (ib[i]) n[i]++;
            idle(1);
        end
        for (int i = 0; i < 3; i++) check($sformatf("busy_len%0d", i), 32'(n[i]), 32'(dep[i]));
    endtask

    initial begin
        dep = '{16, 16, 12};
        lat = '{1, 2, 1};
        wf  = '{1, 0, 1};
        iv  = '{8'h00, 8'h00, 8'h5A};
        #2;
        do_reset();
        count_busy();

        // every word holds the init value after the power-up clear
        for (int a = 0; a < 16; a++) rd(a);
        idle(2);

        wr(3, 8'hA5);
        wr(7, 8'h11);
        wr(4, 8'h42);
        rd(3);
        idle(2);
        rd(3);
        rd(4);
        idle(2);

        // read-during-write on one address, then a plain follow-up read
        step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        rd(7);
        idle(2);

        for (int a = 0; a < 16; a++) wr(a, 8'h80 + 8'(a));
        step(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1, 4'd5);
        for (int k = 1; k <= 10; k++) step(k == 5, 1'b1, 4'(k), 8'hEE, 1'b1, 4'(k));
        idle(8);
        for (int a = 0; a < 16; a++) rd(a);
        idle(2);

        // out-of-range traffic on the 12-word instance
        wr(13, 8'h77);
        rd(13);
        rd(11);
        idle(2);

        // reset with a read still in the two-stage pipeline
        rd(3);
        do_reset();
        idle(8);
        do_reset();
        count_busy();
        rd(0);
        rd(9);
        idle(3);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
